mul_div_unit: RTL and testbench

Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It sits directly downstream of the register file and consumes its two read-port values as operands. Results go to architectural HI/LO registers. MFHI/MFLO results return to the register-file write port through the writeback mux; MTHI/MTLO write HI/LO directly.

---
 rtl/mul_div_unit_if.sv | 16 +
 rtl/mul_div_unit.sv | 81 ++++++++
 tb/tb_mul_div_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand/control bus between the register file side and the HI/LO multiply-divide unit
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, src_a, src_b, hi_we, lo_we, wdata, input busy, done, hi, lo);
  modport slave (input start, op, src_a, src_b, hi_we, lo_we, wdata, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: 32-cycle iterative MULT/MULTU/DIV/DIVU with sign fix-up into architectural HI/LO
module mul_div_unit (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;
  logic [31:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic        is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, bz_q, bz_d, done_q, done_d;
  logic        accept, sgn, ge;
  logic [31:0] mag_a, mag_b, quo, rem;
  logic [32:0] msum, tr, tsub;
  logic [63:0] prod;
  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (bus.start ? CALC : IDLE) :
              state_q == CALC ? (cnt_q == 5'd31 ? FIX : CALC) : IDLE;
  always_comb begin
    bus.busy = state_q != IDLE;
    bus.done = done_q;
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end
  always_comb begin
    accept   = state_q == IDLE && bus.start;
    sgn      = ~bus.op[0];
    mag_a    = sgn && bus.src_a[31] ? -bus.src_a : bus.src_a;
    mag_b    = sgn && bus.src_b[31] ? -bus.src_b : bus.src_b;
    msum     = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
    tr       = p_q[63:31];
    tsub     = tr - {1'b0, m_q};
    ge       = ~tsub[32];
    prod     = neg_q ? -p_q : p_q;
    quo      = bz_q ? 32'hFFFF_FFFF : neg_q ? -p_q[31:0] : p_q[31:0];
    rem      = rneg_q ? -p_q[63:32] : p_q[63:32];
    cnt_d    = state_q == CALC ? cnt_q + 5'd1 : 5'd0;
    done_d   = state_q == FIX;
    is_div_d = accept ? bus.op[1] : is_div_q;
    neg_d    = accept ? sgn & (bus.src_a[31] ^ bus.src_b[31]) : neg_q;
    rneg_d   = accept ? sgn & bus.src_a[31] : rneg_q;
    bz_d     = accept ? bus.op[1] && bus.src_b == 32'd0 : bz_q;
    m_d      = accept ? (bus.op[1] ? mag_b : mag_a) : m_q;
    // divide keeps {remainder, dividend/quotient}; multiply keeps {partial sum, multiplier}
    p_d      = accept ? {32'd0, bus.op[1] ? mag_a : mag_b} :
               state_q != CALC ? p_q :
               is_div_q ? {ge ? tsub[31:0] : tr[31:0], p_q[30:0], ge} : {msum, p_q[31:1]};
    hi_d     = state_q == FIX ? (is_div_q ? rem : prod[63:32]) :
               state_q == IDLE && !bus.start && bus.hi_we ? bus.wdata : hi_q;
    lo_d     = state_q == FIX ? (is_div_q ? quo : prod[31:0]) :
               state_q == IDLE && !bus.start && bus.lo_we ? bus.wdata : lo_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt_q    <= 5'd0;
      p_q      <= 64'd0;
      m_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bz_q     <= bz_d;
      done_q   <= done_d;
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of mul_div_unit results, latency, MTHI/MTLO and reset abort
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   bc, lat, dcnt;
  mul_div_unit_if bus ();
  mul_div_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int busy_cnt, output int latency);
    busy_cnt = 0;
    latency  = 1;
    while (bus.done !== 1'b1 && latency < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      latency++;
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    launch(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done(bc, lat);
    chk("mult_lat", 32'(lat), 32'd34);
    chk("mult_busy_cycles", 32'(bc), 32'd33);
    chk("mult_busy_at_done", 32'(bus.busy), 32'd0);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFF1);
    @(negedge clk);
    chk("done_single", 32'(bus.done), 32'd0);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc, lat);
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    @(negedge clk);
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc, lat);
    chk("mult_m1_hi", bus.hi, 32'd0);
    chk("mult_m1_lo", bus.lo, 32'd1);
    @(negedge clk);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc, lat);
    chk("div_lat", 32'(lat), 32'd34);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    @(negedge clk);
    launch(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done(bc, lat);
    chk("div_negb_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_negb_hi", bus.hi, 32'd1);
    @(negedge clk);
    launch(2'b11, 32'd7, 32'd0);
    wait_done(bc, lat);
    chk("divu0_lat", 32'(lat), 32'd34);
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'd7);
    @(negedge clk);
    launch(2'b10, 32'h8000_0000, 32'd0);
    wait_done(bc, lat);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'h8000_0000);
    @(negedge clk);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc, lat);
    chk("div_ovf_lo", bus.lo, 32'h8000_0000);
    chk("div_ovf_hi", bus.hi, 32'd0);
    @(negedge clk);
    launch(2'b11, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    launch(2'b01, 32'd3, 32'd3);
    wait_done(bc, lat);
    chk("ign_lo", bus.lo, 32'd14);
    chk("ign_hi", bus.hi, 32'd2);
    launch(2'b01, 32'd6, 32'd7);
    wait_done(bc, lat);
    chk("b2b_lat", 32'(lat), 32'd34);
    chk("b2b_lo", bus.lo, 32'd42);
    chk("b2b_hi", bus.hi, 32'd0);
    @(negedge clk);
    launch(2'b00, 32'd3, 32'd5);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("mthi", bus.hi, 32'hDEAD_BEEF);
    chk("mtlo", bus.lo, 32'hDEAD_BEEF);
    launch(2'b01, 32'd2, 32'd3);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi_busy", bus.hi, 32'hDEAD_BEEF);
    chk("calc_lo_hold", bus.lo, 32'hDEAD_BEEF);
    wait_done(bc, lat);
    chk("mul6_hi", bus.hi, 32'd0);
    chk("mul6_lo", bus.lo, 32'd6);
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_0055;
    launch(2'b01, 32'd1, 32'd1);
    bus.lo_we = 1'b0;
    chk("start_drops_mtlo", bus.lo, 32'd6);
    wait_done(bc, lat);
    chk("mul1_lo", bus.lo, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
